miner_core_sched: RTL

MINER_CORE_SCHED -- requirements
Module: miner_core_sched

---
 rtl/miner_pkg.sv | 24 ++
 rtl/miner_core_sigma.sv | 19 +
 rtl/miner_core_sched.sv | 96 +++++++++
 3 files changed

// File: rtl/miner_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | miner_pkg : shared types and sizes for the miner message schedule  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package miner_pkg;

  localparam int SCHED_WORDS = 64;
  localparam int BLOCK_WORDS = 16;

  typedef logic [0:31] word_t;

  typedef enum logic [1:0] {
    SCHED_IDLE   = 2'd0,
    SCHED_EXPAND = 2'd1,
    SCHED_DONE   = 2'd2
  } sched_state_t;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

endpackage
`default_nettype wire

// File: rtl/miner_core_sigma.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | miner_core_sigma : combinational small-sigma0/sigma1 of the        |
// | SHA-256 message schedule.                        Rev 1.0           |
// +--------------------------------------------------------------------+
module miner_core_sigma
  import miner_pkg::*;
(
  input  word_t s0_in,
  input  word_t s1_in,
  output word_t s0_out,
  output word_t s1_out
);

  assign s0_out = rotr(s0_in, 7)  ^ rotr(s0_in, 18) ^ (s0_in >> 3);
  assign s1_out = rotr(s1_in, 17) ^ rotr(s1_in, 19) ^ (s1_in >> 10);

endmodule
`default_nettype wire

// File: rtl/miner_core_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | miner_core_sched : expands a 16-word block into the 64-word        |
// | message schedule, one word per cycle. Option: MINER_SCHED_STREAM_EN|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module miner_core_sched
  import miner_pkg::*;
(
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          sched_en,
  input  logic [0:BLOCK_WORDS-1][0:31]  block,
  output logic [0:SCHED_WORDS-1][0:31]  w,
  output logic                          busy,
  output logic                          sched_done
`ifdef MINER_SCHED_STREAM_EN
  ,
  output logic [0:31]                   w_stream,
  output logic [5:0]                    w_stream_idx,
  output logic                          w_stream_valid
`endif
);

  localparam logic [5:0] c_first_idx = 6'(BLOCK_WORDS);
  localparam logic [5:0] c_last_idx  = 6'(SCHED_WORDS - 1);
  localparam logic [(SCHED_WORDS-BLOCK_WORDS)*32-1:0] c_zero_tail = '0;

  sched_state_t r_state;
  sched_state_t w_state_next;
  logic [5:0]   r_t;
  word_t        w_s0;
  word_t        w_s1;
  word_t        w_new_word;

  miner_core_sigma u_sigma (
    .s0_in  (w[r_t - 6'd15]),
    .s1_in  (w[r_t - 6'd2]),
    .s0_out (w_s0),
    .s1_out (w_s1)
  );

  assign w_new_word = w_s1 + w[r_t - 6'd7] + w_s0 + w[r_t - 6'd16];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SCHED_IDLE:   if (sched_en) w_state_next = SCHED_EXPAND;
      SCHED_EXPAND: if (r_t == c_last_idx) w_state_next = SCHED_DONE;
      SCHED_DONE:   w_state_next = SCHED_IDLE;
      default:      w_state_next = SCHED_IDLE;
    endcase
  end

  // t parks at the last index so it never wraps back into the block words
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= SCHED_IDLE;
      r_t     <= '0;
      w       <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        SCHED_IDLE: begin
          if (sched_en) begin
            w   <= {block, c_zero_tail};
            r_t <= c_first_idx;
          end
        end
        SCHED_EXPAND: begin
          w[r_t] <= w_new_word;
          if (r_t != c_last_idx) r_t <= r_t + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state != SCHED_IDLE);
  assign sched_done = (r_state == SCHED_DONE);

`ifdef MINER_SCHED_STREAM_EN
  always_comb begin
    w_stream       = '0;
    w_stream_idx   = '0;
    w_stream_valid = 1'b0;
    if (r_state == SCHED_EXPAND) begin
      w_stream       = w_new_word;
      w_stream_idx   = r_t;
      w_stream_valid = 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire
